// File: rtl/video_timing_pkg.sv
`timescale 1ns/1ps
// Shared raster timing types: FSM states, 640x480@60 defaults and region-bound derivation.
package video_timing_pkg;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_RUN
  } vt_state_e;

  localparam int unsigned DEF_H_ACTIVE  = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_ACTIVE  = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;
  localparam int unsigned DEF_LOCK_WAIT = 1024;

  // act_end and sync_end are exclusive bounds; last is TOTAL-1
  typedef struct packed {
    logic [11:0] act_end;
    logic [11:0] sync_start;
    logic [11:0] sync_end;
    logic [11:0] last;
  } vt_bounds_t;

  function automatic vt_bounds_t vt_bounds(input int unsigned active, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
    vt_bounds_t b;
    b.act_end    = 12'(active);
    b.sync_start = 12'(active + fp);
    b.sync_end   = 12'(active + fp + sync);
    b.last       = 12'(active + fp + sync + bp - 1);
    return b;
  endfunction

endpackage

// File: rtl/video_lock_qualifier.sv
`timescale 1ns/1ps
// Settle counter for PLL lock qualification: counts consecutive cycles of lock && enable
// while the timing FSM is settling; any dropout restarts the count from zero.
module video_lock_qualifier #(
  parameter int unsigned LOCK_WAIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic enable,
  input  logic settle,
  output logic qualified,
  output logic lost
);

  localparam int unsigned   CW     = $clog2(LOCK_WAIT + 1);
  localparam logic [CW-1:0] TARGET = CW'(LOCK_WAIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          good;

  always_comb begin
    good  = pll_locked && enable;
    cnt_d = '0;
    if (settle && good) begin
      cnt_d = (cnt_q == TARGET) ? cnt_q : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign qualified = settle && (cnt_q == TARGET);
  assign lost      = !pll_locked;

endmodule

// File: rtl/audio_system_video_timing_gen.sv
`timescale 1ns/1ps
// Raster timing generator: qualifies PLL lock, then produces sync, blanking, DE and
// coordinates; all outputs are idle outside RUN.
module audio_system_video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP,
  parameter logic        SYNC_ACTIVE = 1'b0,
  parameter int unsigned LOCK_WAIT   = DEF_LOCK_WAIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_locked,
  input  logic        enable,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        blank_n,
  output logic [11:0] pixel_x,
  output logic [11:0] pixel_y,
  output logic        sof,
  output logic        eol,
  output logic [15:0] frame_count,
  output logic        running
);

  localparam vt_bounds_t HB        = vt_bounds(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam vt_bounds_t VB        = vt_bounds(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic       SYNC_IDLE = ~SYNC_ACTIVE;

  vt_state_e   state_q, state_d;
  logic [11:0] h_q, h_d, v_q, v_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic        sof_q, sof_d, eol_q, eol_d, run_q, run_d;
  logic        qualified, lost, go, frame_end;

  video_lock_qualifier #(
    .LOCK_WAIT(LOCK_WAIT)
  ) u_lock_qual (
    .clk       (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .enable    (enable),
    .settle    (state_q == ST_SETTLE),
    .qualified (qualified),
    .lost      (lost)
  );

  // Output flops are fed from next-state values so the coordinate and its decodes land together
  always_comb begin
    go            = pll_locked && enable;
    frame_end     = (h_q == HB.last) && (v_q == VB.last);
    state_d       = state_q;
    h_d           = '0;
    v_d           = '0;
    frame_count_d = frame_count_q;
    unique case (state_q)
      ST_WAIT: begin
        if (go) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!go) state_d = ST_WAIT;
        else if (qualified) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (frame_end) frame_count_d = frame_count_q + 16'd1;
        // lock loss wins over the end-of-frame checks, but a completed frame still counts
        if (lost || (frame_end && !enable)) begin
          state_d = ST_WAIT;
        end else if (h_q == HB.last) begin
          v_d = (v_q == VB.last) ? '0 : v_q + 12'd1;
        end else begin
          h_d = h_q + 12'd1;
          v_d = v_q;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    run_d = (state_d == ST_RUN);
    de_d  = run_d && (h_d < HB.act_end) && (v_d < VB.act_end);
    hs_d  = (run_d && (h_d >= HB.sync_start) && (h_d < HB.sync_end)) ? SYNC_ACTIVE : SYNC_IDLE;
    vs_d  = (run_d && (v_d >= VB.sync_start) && (v_d < VB.sync_end)) ? SYNC_ACTIVE : SYNC_IDLE;
    sof_d = run_d && (h_d == '0) && (v_d == '0);
    eol_d = run_d && (h_d == HB.last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_WAIT;
      h_q           <= '0;
      v_q           <= '0;
      frame_count_q <= '0;
      hs_q          <= SYNC_IDLE;
      vs_q          <= SYNC_IDLE;
      de_q          <= 1'b0;
      sof_q         <= 1'b0;
      eol_q         <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      frame_count_q <= frame_count_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      sof_q         <= sof_d;
      eol_q         <= eol_d;
      run_q         <= run_d;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign blank_n     = de_q;
  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign sof         = sof_q;
  assign eol         = eol_q;
  assign frame_count = frame_count_q;
  assign running     = run_q;

endmodule

// File: doc/audio_system_video_timing_gen.md
# audio_system_video_timing_gen

Raster timing generator in the video clock domain, directly downstream of the video PLL. Clocked by the PLL's 25 MHz pixel output, it qualifies the PLL `locked` signal and produces 640x480@60 sync, blanking, data-enable and pixel coordinates for the video output path. It holds all video outputs idle until the clock is proven stable, and stops cleanly on loss of lock or on request.

## Interface
- `H_ACTIVE`, 640: active pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48: horizontal front porch, sync and back porch, in pixels
- `V_ACTIVE`, 480: active lines per frame
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33: vertical front porch, sync and back porch, in lines
- `SYNC_ACTIVE`, 0: asserted level of `hsync`/`vsync`; 0 means active-low
- `LOCK_WAIT`, 1024: consecutive qualified cycles required before running (≥1)
- `clk`  in  1  pixel clock (PLL outclk_0, 25 MHz)
- `rst`  in  1  synchronous, active-high reset
- `pll_locked`  in  1  PLL lock; already synchronous to `clk`
- `enable`  in  1  run request from control; level-sensitive
- `hsync`, `vsync`  out  1 each  sync pulses at `SYNC_ACTIVE` polarity
- `de`  out  1  active video
- `blank_n`  out  1  equals `de`; kept for the DAC interface
- `pixel_x`, `pixel_y`  out  12 each  current coordinate, zero-extended
- `sof`  out  1  one-cycle pulse at pixel (0,0)
- `eol`  out  1  one-cycle pulse at the last pixel of each line (`h`=H_TOTAL−1)
- `frame_count`  out  16  completed frames; wraps at 0xFFFF→0
- `running`  out  1  high in state RUN

## Operation
- Derived values: H_TOTAL = sum of the four H parameters (800 by default); V_TOTAL = sum of the four V parameters (525 by default).
- Counters `h` (0..H_TOTAL−1) and `v` (0..V_TOTAL−1). `h` wraps to 0 and increments `v`. `v` wraps to 0 at the end of a frame.
- Regions, using `h`; `v` follows the same pattern:
  - active: 0..H_ACTIVE−1
  - front porch: up to H_ACTIVE+H_FP−1
  - sync: H_ACTIVE+H_FP .. H_ACTIVE+H_FP+H_SYNC−1 (656..751 by default)
  - back porch: the remainder
- Vertical sync lines are 490..491 by default.
- `de` = h active AND v active. `pixel_x`/`pixel_y` equal `h`/`v` in every region, including blanking.
- State machine (reset → WAIT):
  - WAIT: settle counter held at 0. Go to SETTLE when `pll_locked`&&`enable`.
  - SETTLE: counts cycles while `pll_locked`&&`enable`. Any cycle where either is low returns to WAIT and clears the count. Go to RUN after LOCK_WAIT consecutive qualified cycles. `h`, `v` are loaded to 0 on entry to RUN.
  - RUN: counters advance every cycle.
    - `pll_locked` low → WAIT on the next edge. This aborts mid-frame, and `frame_count` is not incremented.
    - At the last pixel of the frame (`h`=H_TOTAL−1, `v`=V_TOTAL−1), `frame_count` increments. If `enable` is low in that cycle, go to WAIT; otherwise wrap to (0,0).
    - `enable` falling mid-frame has no effect until the frame ends.
- Lock loss has priority over the end-of-frame checks when both occur in the same cycle. `frame_count` still increments in that cycle, because the frame completed.
- Outside RUN, outputs are forced idle: sync at the inactive level; `de`, `blank_n`, `sof`, `eol` = 0; `pixel_x`/`pixel_y` = 0. `frame_count` holds its value.

## Timing
- Reset values:
  - `hsync` = `vsync` = ~SYNC_ACTIVE
  - `de` = `blank_n` = `sof` = `eol` = `running` = 0
  - `pixel_x` = `pixel_y` = 0
  - `frame_count` = 0
  - state = WAIT, settle count = 0
- `rst` overrides everything, including mid-frame, taking effect on the next edge.
- All outputs are registered and mutually aligned. The outputs for coordinate (x,y) are all presented in the same cycle, with zero skew between `de`, the syncs and the coordinates.
- The first RUN cycle presents (0,0) with `sof`=1 and `running`=1. It occurs exactly LOCK_WAIT+1 edges after the first edge that samples `pll_locked`&&`enable` high from WAIT.
- Line period is H_TOTAL cycles; frame period is H_TOTAL×V_TOTAL = 420000 cycles.
- Leaving RUN takes effect on the next edge, and outputs are idle from that cycle onward.

## Structure
- Shared package `video_timing_pkg` holds:
  - the state enum (WAIT, SETTLE, RUN)
  - the 640x480 default timing constants
  - the function computing H_TOTAL/V_TOTAL and the region bounds
- One sub-module, `video_lock_qualifier`, handles the settle counter plus the `pll_locked`/`enable` debounce. It outputs `qualified` (LOCK_WAIT reached) and `lost` (lock low).

## Test plan
- **Startup:** `rst` 3 cycles, then `pll_locked`=`enable`=1 with LOCK_WAIT=16 → first `sof` 17 edges later, at (0,0). Outputs are idle before that.
- **Full frame check:** count per frame `de`=1 cycles = 307200, `hsync` active cycles per line = 96, `vsync` active = 2 lines = 1600 cycles. `eol` period = 800 cycles; `sof` period = 420000 cycles.
- **Lock glitch during SETTLE:** drop `pll_locked` at settle count 10 → stays idle. Re-qualifying requires a full 16 cycles.
- **Lock loss mid-frame:** drop `pll_locked` at (300,200) → idle on the next cycle, `frame_count` unchanged. Re-lock → the new frame starts at (0,0).
- **Disable mid-frame:** drop `enable` at (100,100) → the frame completes, `frame_count` increments by 1, then WAIT with idle outputs.
- **Wrap and polarity:** preload `frame_count`=0xFFFF and complete a frame → 0. Run with SYNC_ACTIVE=1 → sync pulses are inverted and the reset level is 0.
